// File: rtl/rv32c_pkg.sv
// Shared types and constants for the RV32C instruction fetch path.
package rv32c_pkg;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        READY    = 2'd1,
        STRADDLE = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [1:0]  OP_32            = 2'b11;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_realign.sv
// Halfword selection and compressed detection for the buffered fetch word.
module fetch_realign
    import rv32c_pkg::*;
(
    input  logic [31:0] word,
    input  logic [15:0] held,
    input  logic        hi_sel,
    input  logic        strad,
    output logic [31:0] inst,
    output logic        is_c,
    output logic        need_straddle
);
    logic [15:0] half;

    always_comb begin
        half          = hi_sel ? word[31:16] : word[15:0];
        is_c          = (half[1:0] != OP_32);
        need_straddle = 1'b0;
        inst          = {16'h0000, half};
        if (strad) begin
            // held upper half of the previous word plus low half of this one
            inst = {word[15:0], held};
            is_c = 1'b0;
        end else if (!is_c) begin
            if (hi_sel)
                need_straddle = 1'b1;
            else
                inst = word;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32IC fetch: one-word buffer, halfword realignment, straddle handling and redirect.
module fetch_unit
    import rv32c_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_is_c,
    output logic [31:0] pc_plus_next
);
    localparam logic [31:0] PC0   = RESET_PC & ~32'd1;
    localparam logic [31:0] ADDR0 = RESET_PC & ~32'd3;

    fetch_state_e state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  req_addr, addr_n;
    logic [31:0]  fbuf, fbuf_n;
    logic [15:0]  held, held_n;
    logic         strad, strad_n;
    logic         discard, discard_n;

    logic [31:0]  al_inst;
    logic         al_is_c;
    logic         need_straddle;

    fetch_realign u_realign (
        .word          (fbuf),
        .held          (held),
        .hi_sel        (pc[1]),
        .strad         (strad),
        .inst          (al_inst),
        .is_c          (al_is_c),
        .need_straddle (need_straddle)
    );

    // Request is held from issue until ack; only READY has nothing outstanding.
    assign imem_req     = !rst && (state != READY);
    assign imem_addr    = req_addr;
    assign inst_valid   = (state == READY) && !need_straddle;
    assign inst         = inst_valid ? al_inst : 32'h0;
    assign inst_is_c    = inst_valid && al_is_c;
    assign inst_pc      = pc;
    assign pc_plus_next = pc + (inst_is_c ? 32'd2 : 32'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= PC0;
            req_addr <= ADDR0;
            fbuf     <= 32'h0;
            held     <= 16'h0;
            strad    <= 1'b0;
            discard  <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_addr <= addr_n;
            fbuf     <= fbuf_n;
            held     <= held_n;
            strad    <= strad_n;
            discard  <= discard_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        addr_n    = req_addr;
        fbuf_n    = fbuf;
        held_n    = held;
        strad_n   = strad;
        discard_n = discard;
        case (state)
            FETCH: begin
                if (imem_ack) begin
                    if (discard) begin
                        discard_n = 1'b0;
                        addr_n    = word_addr(pc);
                    end else begin
                        fbuf_n  = imem_rdata;
                        state_n = READY;
                    end
                end
            end
            STRADDLE: begin
                if (imem_ack) begin
                    fbuf_n  = imem_rdata;
                    strad_n = 1'b1;
                    state_n = READY;
                end
            end
            READY: begin
                if (need_straddle) begin
                    held_n  = fbuf[31:16];
                    addr_n  = word_addr(pc) + 32'd4;
                    state_n = STRADDLE;
                end else if (inst_ready) begin
                    pc_n = pc_plus_next;
                    // after a straddle the buffer already holds the next word
                    if (strad) begin
                        strad_n = 1'b0;
                    end else if (pc_plus_next[31:2] != pc[31:2]) begin
                        addr_n  = word_addr(pc_plus_next);
                        state_n = FETCH;
                    end
                end
            end
            default: state_n = FETCH;
        endcase
        if (redirect_valid) begin
            pc_n    = redirect_pc & ~32'd1;
            strad_n = 1'b0;
            state_n = FETCH;
            if (state != READY && !imem_ack) begin
                // let the in-flight request finish at its original address
                discard_n = 1'b1;
                addr_n    = req_addr;
            end else begin
                discard_n = 1'b0;
                addr_n    = word_addr(pc_n);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, alignment, straddle, redirect, stall, wrap.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_is_c;
    logic [31:0] pc_plus_next;

    int tests = 0;
    int fails = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .inst_is_c(inst_is_c),
        .pc_plus_next(pc_plus_next)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; redirect_valid = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0;
        tick; tick;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        #1;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b want 0", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got %h want 0", imem_addr); end
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", inst_valid); end
        tests++; if (inst !== 32'h0) begin fails++; $display("FAIL rst_inst got %h want 0", inst); end
        tests++; if (inst_pc !== 32'h0) begin fails++; $display("FAIL rst_pc got %h want 0", inst_pc); end
        tests++; if (inst_is_c !== 1'b0) begin fails++; $display("FAIL rst_is_c got %b want 0", inst_is_c); end
        tick;
        rst = 1'b0;
        #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            begin fails++; $display("FAIL post_rst_req got %b/%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_basic;
        imem_rdata = 32'h0000_0513; imem_ack = 1'b1;
        #1;
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL valid_on_ack got %b want 0", inst_valid); end
        tick;
        imem_ack = 1'b0;
        tests++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0513)
            begin fails++; $display("FAIL basic_inst got %b/%h want 1/00000513", inst_valid, inst); end
        tests++; if (inst_is_c !== 1'b0 || pc_plus_next !== 32'd4 || inst_pc !== 32'd0)
            begin fails++; $display("FAIL basic_meta got %b/%h/%h want 0/4/0", inst_is_c, pc_plus_next, inst_pc); end
        inst_ready = 1'b1;
        tick;
        inst_ready = 1'b0;
        tests++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd4)
            begin fails++; $display("FAIL basic_next_req got %b/%b/%h want 0/1/4", inst_valid, imem_req, imem_addr); end
    endtask

    task automatic test_compressed;
        do_reset;
        imem_rdata = 32'h4505_4501; imem_ack = 1'b1;
        tick;
        imem_ack = 1'b0;
        tests++; if (inst_valid !== 1'b1 || inst !== 32'h0000_4501 || inst_is_c !== 1'b1 || inst_pc !== 32'd0)
            begin fails++; $display("FAIL c_first got %b/%h/%b/%h want 1/00004501/1/0", inst_valid, inst, inst_is_c, inst_pc); end
        tests++; if (pc_plus_next !== 32'd2) begin fails++; $display("FAIL c_ppn got %h want 2", pc_plus_next); end
        inst_ready = 1'b1;
        tick;
        tests++; if (inst_valid !== 1'b1 || inst !== 32'h0000_4505 || inst_pc !== 32'd2 || inst_is_c !== 1'b1)
            begin fails++; $display("FAIL c_second got %b/%h/%h/%b want 1/00004505/2/1", inst_valid, inst, inst_pc, inst_is_c); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL c_one_req got %b want 0", imem_req); end
        tick;
        inst_ready = 1'b0;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'd4 || inst_valid !== 1'b0)
            begin fails++; $display("FAIL c_next_word got %b/%h/%b want 1/4/0", imem_req, imem_addr, inst_valid); end
    endtask

    task automatic test_straddle;
        do_reset;
        // redirect to 2 in the same cycle as ack: the returned word is dropped
        redirect_valid = 1'b1; redirect_pc = 32'd2;
        imem_rdata = 32'hFFFF_FFFF; imem_ack = 1'b1;
        tick;
        redirect_valid = 1'b0; imem_ack = 1'b0;
        tests++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0 || inst_pc !== 32'd2)
            begin fails++; $display("FAIL strad_redir got %b/%b/%h/%h want 0/1/0/2", inst_valid, imem_req, imem_addr, inst_pc); end
        imem_rdata = 32'h0513_1234; imem_ack = 1'b1;
        tick;
        imem_ack = 1'b0;
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL strad_hold got %b want 0", inst_valid); end
        tick;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'd4)
            begin fails++; $display("FAIL strad_req got %b/%h want 1/4", imem_req, imem_addr); end
        imem_rdata = 32'hABCD_0000; imem_ack = 1'b1;
        tick;
        imem_ack = 1'b0;
        tests++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0513 || inst_pc !== 32'd2)
            begin fails++; $display("FAIL strad_inst got %b/%h/%h want 1/00000513/2", inst_valid, inst, inst_pc); end
        tests++; if (pc_plus_next !== 32'd6 || inst_is_c !== 1'b0)
            begin fails++; $display("FAIL strad_ppn got %h/%b want 6/0", pc_plus_next, inst_is_c); end
        inst_ready = 1'b1;
        tick;
        inst_ready = 1'b0;
        tests++; if (inst_valid !== 1'b1 || inst !== 32'h0000_ABCD || inst_pc !== 32'd6 || inst_is_c !== 1'b1 || imem_req !== 1'b0)
            begin fails++; $display("FAIL strad_reuse got %b/%h/%h/%b/%b want 1/0000abcd/6/1/0", inst_valid, inst, inst_pc, inst_is_c, imem_req); end
    endtask

    task automatic test_redirect_outstanding;
        do_reset;
        redirect_valid = 1'b1; redirect_pc = 32'd8;
        imem_rdata = 32'h0; imem_ack = 1'b1;
        tick;
        imem_ack = 1'b0;
        redirect_pc = 32'h100;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'd8)
            begin fails++; $display("FAIL ro_req8 got %b/%h want 1/8", imem_req, imem_addr); end
        tick;
        redirect_valid = 1'b0;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'd8 || inst_valid !== 1'b0)
            begin fails++; $display("FAIL ro_stable got %b/%h/%b want 1/8/0", imem_req, imem_addr, inst_valid); end
        tick; tick;
        imem_rdata = 32'hDEAD_BEEF; imem_ack = 1'b1;
        tick;
        imem_ack = 1'b0;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0)
            begin fails++; $display("FAIL ro_drop got %b/%h/%b want 1/100/0", imem_req, imem_addr, inst_valid); end
        imem_rdata = 32'h0000_0513; imem_ack = 1'b1;
        tick;
        imem_ack = 1'b0;
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== 32'h0000_0513)
            begin fails++; $display("FAIL ro_new got %b/%h/%h want 1/100/00000513", inst_valid, inst_pc, inst); end
    endtask

    task automatic test_stall_redirect;
        int bad = 0;
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (inst_valid !== 1'b1 || inst !== 32'h0000_0513 || inst_pc !== 32'h100) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL stall_stable got %0d unstable cycles want 0", bad); end
        redirect_valid = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b1;
        tick;
        redirect_valid = 1'b0; inst_ready = 1'b0;
        tests++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200)
            begin fails++; $display("FAIL hs_redir got %b/%b/%h want 0/1/200", inst_valid, imem_req, imem_addr); end
        imem_rdata = 32'h0000_4501; imem_ack = 1'b1;
        tick;
        imem_ack = 1'b0;
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== 32'h0000_4501)
            begin fails++; $display("FAIL hs_target got %b/%h/%h want 1/200/00004501", inst_valid, inst_pc, inst); end
    endtask

    task automatic test_reset_mid_fetch;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick;
        redirect_valid = 1'b0;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h40)
            begin fails++; $display("FAIL rmf_req got %b/%h want 1/40", imem_req, imem_addr); end
        rst = 1'b1;
        #1;
        tests++; if (imem_req !== 1'b0 || inst_valid !== 1'b0)
            begin fails++; $display("FAIL rmf_in_rst got %b/%b want 0/0", imem_req, inst_valid); end
        tick;
        imem_rdata = 32'h0000_0513; imem_ack = 1'b1;
        tick;
        imem_ack = 1'b0;
        rst = 1'b0;
        #1;
        tests++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0)
            begin fails++; $display("FAIL rmf_after got %b/%b/%h want 0/1/0", inst_valid, imem_req, imem_addr); end
        tick;
        tests++; if (inst_valid !== 1'b0 || inst_pc !== 32'h0)
            begin fails++; $display("FAIL rmf_late got %b/%h want 0/0", inst_valid, inst_pc); end
    endtask

    task automatic test_wrap;
        do_reset;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        imem_rdata = 32'h0; imem_ack = 1'b1;
        tick;
        redirect_valid = 1'b0; imem_ack = 1'b0;
        tests++; if (imem_addr !== 32'hFFFF_FFFC || inst_pc !== 32'hFFFF_FFFE)
            begin fails++; $display("FAIL wrap_addr got %h/%h want fffffffc/fffffffe", imem_addr, inst_pc); end
        imem_rdata = 32'h4501_0000; imem_ack = 1'b1;
        tick;
        imem_ack = 1'b0;
        tests++; if (inst_valid !== 1'b1 || inst !== 32'h0000_4501 || inst_is_c !== 1'b1 || pc_plus_next !== 32'h0)
            begin fails++; $display("FAIL wrap_inst got %b/%h/%b/%h want 1/00004501/1/0", inst_valid, inst, inst_is_c, pc_plus_next); end
        inst_ready = 1'b1;
        tick;
        inst_ready = 1'b0;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_pc !== 32'h0)
            begin fails++; $display("FAIL wrap_next got %b/%h/%h want 1/0/0", imem_req, imem_addr, inst_pc); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_compressed;
        test_straddle;
        test_redirect_outstanding;
        test_stall_redirect;
        test_reset_mid_fetch;
        test_wrap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
